instr_mem_loadable: RTL and testbench

Parametrised, synchronous instruction memory that replaces the fixed combinational program ROM. It holds DEPTH words of DATA_W bits, clears itself to NOP (all-zero) after reset, accepts program words through a load port, and serves the fetch stage through a registered, stallable read port. It sits between the PC/fetch logic and the decode stage. Programs are loaded at run time rather than hard-coded.

---
 rtl/instr_mem_loadable.sv | 161 ++++++++++++++++
 tb/tb_instr_mem_loadable.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: run-time loadable instruction memory.
// After reset the array is cleared to NOP, one word per cycle. Then a
// registered, stallable fetch port and a write-only load port are served.
// A load and a fetch to the same in-range address in one cycle return the
// new word (write-first). Every output comes from a register.
module instr_mem_loadable #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              fetch_hold,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              fetch_err,
    output logic              ready,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH widened by one bit, so that a full-width address compare
    // cannot wrap even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic              ready_q;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic [DATA_W-1:0] out_q,       out_d;
    logic              out_valid_q, out_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              load_err_q,  load_err_d;

    logic              fetch_in_range;
    logic              load_in_range;
    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  load_idx;
    logic              fetch_acc;
    logic              bypass;
    logic [DATA_W-1:0] rd_word;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign fetch_in_range = ({1'b0, address}   < DEPTH_X);
    assign load_in_range  = ({1'b0, load_addr} < DEPTH_X);
    assign fetch_idx      = address[IDX_W-1:0];
    assign load_idx       = load_addr[IDX_W-1:0];

    // Clear sequencer: one word per cycle, DEPTH cycles, then READY until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    end
                end
                S_READY: begin
                    state_q <= S_READY;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Select the single write port: clear writes while clearing, otherwise an in-range load
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clr_cnt_q;
        wr_data = '0;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                wr_en   = 1'b1;
                wr_idx  = clr_cnt_q;
                wr_data = '0;
            end else if (load_en && load_in_range) begin
                wr_en   = 1'b1;
                wr_idx  = load_idx;
                wr_data = load_data;
            end
        end
    end

    // Storage array; the clear sequencer empties it, so it has no reset of its own
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Fetch/load result next-state: write-first bypass, NOP when out of range, hold freezes all
    always_comb begin
        fetch_acc   = ready_q && fetch_en && !fetch_hold;
        bypass      = ready_q && load_en && load_in_range && (load_addr == address);
        rd_word     = bypass ? load_data : mem_q[fetch_idx];

        out_d       = out_q;
        out_valid_d = out_valid_q;
        fetch_err_d = fetch_err_q;

        if (!fetch_hold) begin
            out_valid_d = fetch_acc;
            if (fetch_acc) begin
                fetch_err_d = !fetch_in_range;
                out_d       = fetch_in_range ? rd_word : '0;
            end
        end

        // A dropped load is flagged in the cycle after the offending request
        load_err_d = load_en && (!ready_q || !load_in_range);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            fetch_err_q <= fetch_err_d;
            load_err_q  <= load_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign fetch_err = fetch_err_q;
    assign ready     = ready_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable. A behavioural model predicts the
// complete output vector after each edge and queues it. A monitor pops one
// entry per edge and compares it with the DUT.
module tb_instr_mem_loadable;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic              fetch_hold;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              fetch_err;
    logic              ready;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;

    always #5 clk = ~clk;

    instr_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .fetch_hold(fetch_hold),
        .address   (address),
        .out       (out),
        .out_valid (out_valid),
        .fetch_err (fetch_err),
        .ready     (ready),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_err  (load_err)
    );

    typedef struct packed {
        logic        rdy;
        logic        lerr;
        logic        vld;
        logic        ferr;
        logic [15:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: the word array, the number of cycles since reset,
    // and the last predicted output values.
    logic [15:0] m_mem [DEPTH];
    int          m_cyc = 0;
    exp_t        m_o   = '0;

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        bit          rdy;
        int unsigned a;
        int unsigned la;
        a  = address;
        la = load_addr;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 16'h0;
            m_cyc = 0;
            m_o   = '0;
        end else begin
            rdy = (m_cyc >= DEPTH);
            m_o.lerr = load_en && (!rdy || la >= DEPTH);
            // The write happens first, so a fetch of the same address in the same cycle reads the new word.
            if (rdy && load_en && la < DEPTH) m_mem[la] = load_data;
            if (!fetch_hold) begin
                if (rdy && fetch_en) begin
                    m_o.vld  = 1'b1;
                    m_o.ferr = (a >= DEPTH);
                    m_o.dat  = (a < DEPTH) ? m_mem[a] : 16'h0;
                end else begin
                    m_o.vld = 1'b0;
                end
            end
            m_cyc++;
            m_o.rdy = (m_cyc >= DEPTH);
        end
        sb_q.push_back(m_o);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one registered output vector is presented per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ready",     {31'h0, ready},     {31'h0, e.rdy});
                chk("load_err",  {31'h0, load_err},  {31'h0, e.lerr});
                chk("out_valid", {31'h0, out_valid}, {31'h0, e.vld});
                chk("fetch_err", {31'h0, fetch_err}, {31'h0, e.ferr});
                chk("out",       {16'h0, out},       {16'h0, e.dat});
            end
        end
    end

    // Drive one cycle of inputs, queue the prediction, and step past the edge.
    task automatic cyc(input logic r, input logic fe, input logic fh, input logic [15:0] a,
                       input logic le, input logic [15:0] la, input logic [15:0] ld);
        rst        = r;
        fetch_en   = fe;
        fetch_hold = fh;
        address    = a;
        load_en    = le;
        load_addr  = la;
        load_data  = ld;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic fetch(input logic [15:0] a);
        cyc(1'b0, 1'b1, 1'b0, a, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic load(input logic [15:0] la, input logic [15:0] ld);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, la, ld);
    endtask

    task automatic readback_all();
        for (int i = 0; i < DEPTH; i++) fetch(16'(i));
        idle(1);
    endtask

    task automatic rand_addr(output logic [15:0] a);
        if ($urandom_range(0, 9) < 8) a = 16'($urandom_range(0, DEPTH - 1));
        else                          a = 16'($urandom);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rla;
        int          wait_cnt;

        // Reset, then the clear window. Random fetches and loads during the clear must be ignored or dropped.
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'h3,  1'b1, 16'h3, 16'hAAAA);
        for (int i = 0; i < DEPTH + 4; i++) begin
            rand_addr(ra);
            rand_addr(rla);
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                1'($urandom_range(0, 1)), rla, 16'($urandom));
        end
        idle(1);
        readback_all();

        // Load two words, then fetch back to back.
        load(16'd1, 16'hB040);
        load(16'd3, 16'hC250);
        fetch(16'd1);
        fetch(16'd3);
        fetch(16'd2);
        idle(1);

        // Out-of-range fetches and load; the full-width compare must not wrap 0x8001.
        fetch(16'd64);
        fetch(16'h8001);
        load(16'd70, 16'hDEAD);
        cyc(1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 16'hFFFF, 16'hBEEF);
        idle(1);
        readback_all();

        // A load and a fetch of the same address in the same cycle return the new word.
        cyc(1'b0, 1'b1, 1'b0, 16'd5, 1'b1, 16'd5, 16'hF34B);
        // A load and a fetch to different addresses in the same cycle.
        cyc(1'b0, 1'b1, 1'b0, 16'd5, 1'b1, 16'd6, 16'h1234);
        fetch(16'd6);
        idle(1);

        // Hold freezes the outputs while the address changes.
        fetch(16'd1);
        cyc(1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 16'h0, 16'h0);
        fetch(16'd3);
        fetch(16'd64);
        cyc(1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 16'h0, 16'h0);
        idle(2);

        // Reset in READY after loading, reset again mid-clear, then the full clear and a readback.
        cyc(1'b1, 1'b1, 1'b0, 16'd1, 1'b1, 16'd9, 16'h5555);
        idle(20);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        idle(DEPTH + 1);
        readback_all();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            rand_addr(ra);
            rand_addr(rla);
            if ($urandom_range(0, 3) == 0) rla = ra;
            cyc(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 5) == 0), ra, 1'($urandom_range(0, 2) == 0),
                rla, 16'($urandom));
        end
        idle(DEPTH + 1);
        readback_all();

        // Let the monitor drain, with a bounded wait.
        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            #5;
            wait_cnt++;
        end
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
